// File: rtl/memory_pkg.sv
// Shared data-memory / load-store definitions: access sizes, LSU exception
// codes, LSU FSM state encoding and RV32I load funct3 values.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN (adds the SPLIT state).
package memory_pkg;

    localparam int MEM_ADDR_WIDTH = 16;
    localparam int MEM_WORD_WIDTH = 32;

    // Access size as seen by the data memory (funct3[1:0] of RV32I)
    typedef enum logic [1:0] {
        LS_SINGLE   = 2'd0,
        LS_HALFWORD = 2'd1,
        LS_WORD     = 2'd2
    } ls_size_e;

    typedef enum logic [1:0] {
        LOAD_MISALIGN  = 2'd0,
        STORE_MISALIGN = 2'd1,
        ACCESS_FAULT   = 2'd2,
        ILLEGAL_SIZE   = 2'd3
    } lsu_exc_e;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE   = 2'd0;
    localparam lsu_state_t ST_ACCESS = 2'd1;
    localparam lsu_state_t ST_RESP   = 2'd2;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam lsu_state_t ST_SPLIT  = 2'd3;
`endif

    // Load encodings; stores SB/SH/SW reuse the LB/LH/LW values
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // A funct3 is usable only if it is a known load encoding; stores
    // additionally have no unsigned variants.
    function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
        logic known;
        known = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                (f3 == F3_LBU) || (f3 == F3_LHU);
        return !known || (store && f3[2]);
    endfunction

endpackage

// File: rtl/lsu_ctrl_align.sv
// lsu_align: combinational byte-lane assembly for split accesses and
// sign/zero extension of the raw (right-justified) load value.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN (adds the lane-merge ports).
module lsu_align
    import memory_pkg::*;
#(
    parameter int WORD_W = MEM_WORD_WIDTH
) (
    input  logic [WORD_W-1:0] word_in,
    input  logic [1:0]        size,
    input  logic              l_unsigned,
`ifdef LSU_MISALIGN_SPLIT_EN
    input  logic [1:0]        lane,
    input  logic [7:0]        lane_byte,
    output logic [WORD_W-1:0] merged_word,
`endif
    output logic [WORD_W-1:0] ext_word
);

`ifdef LSU_MISALIGN_SPLIT_EN
    // Drop the incoming byte into its little-endian lane, keep the others
    genvar gi;
    generate
        for (gi = 0; gi < WORD_W / 8; gi++) begin : g_lane
            assign merged_word[8*gi +: 8] = (int'(lane) == gi) ? lane_byte
                                                                : word_in[8*gi +: 8];
        end
    endgenerate
`endif

    // Extend from the low byte/half regardless of what the memory put above it
    always_comb begin
        ext_word = word_in;
        case (size)
            LS_SINGLE:   ext_word = {{(WORD_W-8){~l_unsigned & word_in[7]}}, word_in[7:0]};
            LS_HALFWORD: ext_word = {{(WORD_W-16){~l_unsigned & word_in[15]}}, word_in[15:0]};
            default:     ext_word = word_in;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller between the execute stage and the
// data memory. Data on the memory side is right-justified (byte 0 of the
// access in bits [7:0]). Exceptions are decided at accept time except for
// memory-reported faults, which arrive one cycle after the request.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN (misaligned accesses are
// executed as ascending single-byte accesses instead of trapping).
module lsu_ctrl
    import memory_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_WIDTH,
    parameter int WORD_W = MEM_WORD_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_store,
    input  logic [2:0]        ex_funct3,
    input  logic [31:0]       ex_addr,
    input  logic [WORD_W-1:0] ex_wdata,
    output logic              lsu_done,
    output logic [WORD_W-1:0] lsu_rdata,
    output logic              lsu_exc,
    output logic [1:0]        lsu_exc_cause,
    output logic              dm_req,
    output logic              dm_write_en,
    output logic              dm_l_unsigned,
    output logic [1:0]        dm_n_bytes,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [WORD_W-1:0] dm_store_data,
    input  logic [WORD_W-1:0] dm_load_data,
    input  logic              dm_addr_err
);

    lsu_state_t        state_reg, state_next;
    logic              store_reg;
    logic [2:0]        funct3_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [WORD_W-1:0] wdata_reg;
    logic              exc_pend_reg;
    lsu_exc_e          cause_pend_reg;
    logic              accessed_reg;
    logic [WORD_W-1:0] raw_reg;
    logic [WORD_W-1:0] rdata_hold_reg;
    lsu_exc_e          cause_hold_reg;
    logic [WORD_W-1:0] ext_word;

    logic              accept, dec_illegal, dec_range, dec_misal, dec_exc;
    lsu_exc_e          dec_cause;
    logic              mem_fault, resp_exc;
    lsu_exc_e          resp_cause;
    logic [WORD_W-1:0] resp_rdata;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [1:0]        byte_idx_reg;
    logic              fault_sticky_reg;
    logic [1:0]        last_idx;
    logic [WORD_W-1:0] merged_word;

    assign last_idx = (funct3_reg[1:0] == LS_WORD) ? 2'd3 : 2'd1;
`endif

    // Decode the presented request; precedence illegal > range > misalign
    always_comb begin
        accept      = ex_valid && (state_reg == ST_IDLE);
        dec_illegal = f3_illegal(ex_store, ex_funct3);
        dec_range   = (ex_addr >> ADDR_W) != 32'd0;
        dec_misal   = ((ex_funct3[1:0] == LS_HALFWORD) && ex_addr[0]) ||
                      ((ex_funct3[1:0] == LS_WORD) && (ex_addr[1:0] != 2'b00));
        dec_exc     = dec_illegal || dec_range;
        dec_cause   = dec_illegal ? ILLEGAL_SIZE : ACCESS_FAULT;
`ifndef LSU_MISALIGN_SPLIT_EN
        if (!dec_exc && dec_misal) begin
            dec_exc   = 1'b1;
            dec_cause = ex_store ? STORE_MISALIGN : LOAD_MISALIGN;
        end
`endif
    end

    // Next state: decode-time exceptions skip straight to RESP
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (dec_exc)        state_next = ST_RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
                    else if (dec_misal) state_next = ST_SPLIT;
`endif
                    else                state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: state_next = ST_RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
            ST_SPLIT:  if (byte_idx_reg == last_idx) state_next = ST_RESP;
`endif
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Memory request: only driven while accessing, all zero otherwise
    always_comb begin
        dm_req        = 1'b0;
        dm_write_en   = 1'b0;
        dm_l_unsigned = 1'b0;
        dm_n_bytes    = 2'd0;
        dm_addr       = '0;
        dm_store_data = '0;
        if (state_reg == ST_ACCESS) begin
            dm_req        = 1'b1;
            dm_write_en   = store_reg;
            dm_l_unsigned = funct3_reg[2];
            dm_n_bytes    = funct3_reg[1:0];
            dm_addr       = addr_reg;
            dm_store_data = wdata_reg;
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        if (state_reg == ST_SPLIT) begin
            dm_req        = 1'b1;
            dm_write_en   = store_reg;
            dm_l_unsigned = 1'b1;
            dm_n_bytes    = LS_SINGLE;
            dm_addr       = addr_reg + ADDR_W'(byte_idx_reg);
            dm_store_data = {{(WORD_W-8){1'b0}}, wdata_reg[8*byte_idx_reg +: 8]};
        end
`endif
    end

    lsu_align #(.WORD_W(WORD_W)) u_align (
        .word_in     (raw_reg),
        .size        (funct3_reg[1:0]),
        .l_unsigned  (funct3_reg[2]),
`ifdef LSU_MISALIGN_SPLIT_EN
        .lane        (byte_idx_reg),
        .lane_byte   (dm_load_data[7:0]),
        .merged_word (merged_word),
`endif
        .ext_word    (ext_word)
    );

    // Response: memory faults arrive during RESP, so it is resolved here
    always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
        mem_fault = accessed_reg && (dm_addr_err || fault_sticky_reg);
`else
        mem_fault = accessed_reg && dm_addr_err;
`endif
        resp_exc   = exc_pend_reg || mem_fault;
        resp_cause = exc_pend_reg ? cause_pend_reg
                                  : (mem_fault ? ACCESS_FAULT : cause_hold_reg);
        resp_rdata = (resp_exc || store_reg) ? '0 : ext_word;

        ex_ready      = (state_reg == ST_IDLE);
        lsu_done      = (state_reg == ST_RESP);
        lsu_exc       = lsu_done && resp_exc;
        lsu_exc_cause = lsu_done ? resp_cause : cause_hold_reg;
        lsu_rdata     = lsu_done ? resp_rdata : rdata_hold_reg;
    end

    // State, request latch, load capture and held response values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            store_reg        <= 1'b0;
            funct3_reg       <= 3'd0;
            addr_reg         <= '0;
            wdata_reg        <= '0;
            exc_pend_reg     <= 1'b0;
            cause_pend_reg   <= LOAD_MISALIGN;
            accessed_reg     <= 1'b0;
            raw_reg          <= '0;
            rdata_hold_reg   <= '0;
            cause_hold_reg   <= LOAD_MISALIGN;
`ifdef LSU_MISALIGN_SPLIT_EN
            byte_idx_reg     <= 2'd0;
            fault_sticky_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (accept) begin
                store_reg      <= ex_store;
                funct3_reg     <= ex_funct3;
                addr_reg       <= ex_addr[ADDR_W-1:0];
                wdata_reg      <= ex_wdata;
                exc_pend_reg   <= dec_exc;
                cause_pend_reg <= dec_cause;
                accessed_reg   <= !dec_exc;
                raw_reg        <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
                byte_idx_reg     <= 2'd0;
                fault_sticky_reg <= 1'b0;
`endif
            end
            if (state_reg == ST_ACCESS) begin
                raw_reg <= dm_load_data;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            if (state_reg == ST_SPLIT) begin
                raw_reg      <= merged_word;
                byte_idx_reg <= byte_idx_reg + 2'd1;
                // The fault for byte i shows up while byte i+1 is requested
                if (byte_idx_reg != 2'd0 && dm_addr_err) begin
                    fault_sticky_reg <= 1'b1;
                end
            end
`endif
            if (state_reg == ST_RESP) begin
                rdata_hold_reg <= resp_rdata;
                cause_hold_reg <= resp_cause;
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl with a behavioural data memory.
// Addresses below 0x1000 fault; the memory fills unused upper load bits with
// 0xA5 so the LSU's own extension is exercised.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN (changes expected behaviour).
`timescale 1ns/1ps
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic        ex_store = 1'b0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic [31:0] ex_addr = 32'd0;
    logic [31:0] ex_wdata = 32'd0;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_exc;
    logic [1:0]  lsu_exc_cause;
    logic        dm_req, dm_write_en, dm_l_unsigned;
    logic [1:0]  dm_n_bytes;
    logic [15:0] dm_addr;
    logic [31:0] dm_store_data;
    logic [31:0] dm_load_data;
    logic        dm_addr_err;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_store(ex_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_exc(lsu_exc),
        .lsu_exc_cause(lsu_exc_cause),
        .dm_req(dm_req), .dm_write_en(dm_write_en), .dm_l_unsigned(dm_l_unsigned),
        .dm_n_bytes(dm_n_bytes), .dm_addr(dm_addr), .dm_store_data(dm_store_data),
        .dm_load_data(dm_load_data), .dm_addr_err(dm_addr_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural data memory ----------------
    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];
    bit         mem_init_done = 1'b0;

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            32'h4000: return 8'hEF;
            32'h4001: return 8'hBE;
            32'h4002: return 8'hAD;
            32'h4003: return 8'hDE;
            default:  return 8'(i * 7 + 3);
        endcase
    endfunction

    always_comb begin
        case (dm_n_bytes)
            2'd0:    dm_load_data = {24'hA5A5A5, mem[dm_addr]};
            2'd1:    dm_load_data = {16'hA5A5, mem[dm_addr + 16'd1], mem[dm_addr]};
            default: dm_load_data = {mem[dm_addr + 16'd3], mem[dm_addr + 16'd2],
                                     mem[dm_addr + 16'd1], mem[dm_addr]};
        endcase
    end

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 65536; i++) mem[i] <= init_byte(i);
            mem_init_done <= 1'b1;
        end else if (dm_req && dm_write_en && dm_addr >= 16'h1000) begin
            for (int i = 0; i < (dm_n_bytes == 2'd0 ? 1 : dm_n_bytes == 2'd1 ? 2 : 4); i++)
                mem[dm_addr + 16'(i)] <= dm_store_data[8*i +: 8];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) dm_addr_err <= 1'b0;
        else        dm_addr_err <= dm_req && (dm_addr < 16'h1000);
    end

    // ---------------- expectation model ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        exc;
        logic [1:0]  cause;
        int          lat;
        int          reqs;
    } exp_t;

    exp_t q[$];

    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic exp_t model(input logic st, input logic [2:0] f3, input logic [31:0] a);
        exp_t        e;
        int          n, k;
        logic        mis, flt;
        logic [31:0] v;
        logic [15:0] ai;
        e.rdata = 32'd0; e.exc = 1'b0; e.cause = 2'd0; e.lat = 2; e.reqs = 1;
        n   = nbytes(f3);
        mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
        if (f3[1:0] == 2'd3 || f3 == 3'b110 || (st && f3[2])) begin
            e.exc = 1'b1; e.cause = 2'd3; e.lat = 1; e.reqs = 0;
        end else if (a[31:16] != 16'd0) begin
            e.exc = 1'b1; e.cause = 2'd2; e.lat = 1; e.reqs = 0;
        end else if (mis) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            e.lat = n + 1; e.reqs = n;
`else
            e.exc = 1'b1; e.cause = st ? 2'd1 : 2'd0; e.lat = 1; e.reqs = 0;
`endif
        end
        if (!e.exc) begin
            flt = 1'b0;
            k = (e.reqs > 1) ? n : 1;
            for (int i = 0; i < k; i++) begin
                ai = a[15:0] + 16'(i);
                if (ai < 16'h1000) flt = 1'b1;
            end
            if (flt) begin e.exc = 1'b1; e.cause = 2'd2; end
        end
        if (!e.exc && !st) begin
            v = 32'd0;
            for (int i = 0; i < n; i++) begin
                ai = a[15:0] + 16'(i);
                v[8*i +: 8] = ref_mem[ai];
            end
            if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
            if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
            e.rdata = v;
        end
        return e;
    endfunction

    // ---------------- monitor ----------------
    bit          busy = 1'b0;
    bit          done_flag = 1'b0;
    int          cyc = 0;
    int          reqs = 0;
    logic        cur_st;
    logic [2:0]  cur_f3;
    logic [31:0] cur_a, cur_wd;
    bit          cur_split;
    logic [31:0] last_rdata = 32'd0;
    logic [1:0]  last_cause = 2'd0;
    logic [31:0] last_dut_rdata = 32'd0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (busy) begin
                cyc++;
                if (dm_req) begin
                    chk("dm_addr", {16'd0, dm_addr},
                        {16'd0, cur_a[15:0] + (cur_split ? 16'(reqs) : 16'd0)});
                    chk("dm_we", {31'd0, dm_write_en}, {31'd0, cur_st});
                    chk("dm_nbytes", {30'd0, dm_n_bytes}, cur_split ? 32'd0 : {30'd0, cur_f3[1:0]});
                    chk("dm_lu", {31'd0, dm_l_unsigned}, cur_split ? 32'd1 : {31'd0, cur_f3[2]});
                    if (cur_st) begin
                        if (cur_split) chk("dm_sdata_b", {24'd0, dm_store_data[7:0]},
                                           {24'd0, cur_wd[8*reqs +: 8]});
                        else           chk("dm_sdata", dm_store_data, cur_wd);
                    end
                    reqs++;
                end
                if (lsu_done) begin
                    if (q.size() == 0) begin
                        chk("sb_empty", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("latency", cyc, e.lat);
                        chk("req_count", reqs, e.reqs);
                        chk("exc", {31'd0, lsu_exc}, {31'd0, e.exc});
                        chk("rdata", lsu_rdata, e.rdata);
                        if (e.exc) begin
                            chk("cause", {30'd0, lsu_exc_cause}, {30'd0, e.cause});
                            last_cause = e.cause;
                        end
                        last_rdata = e.rdata;
                    end
                    last_dut_rdata = lsu_rdata;
                    busy = 1'b0;
                    done_flag = 1'b1;
                end
            end else begin
                if (dm_req)   chk("stray_req", {31'd0, dm_req}, 32'd0);
                if (lsu_done) chk("stray_done", {31'd0, lsu_done}, 32'd0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic xact(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
        exp_t e;
        int   k;
        e = model(st, f3, a);
        @(negedge clk);
        ex_valid = 1'b1; ex_store = st; ex_funct3 = f3; ex_addr = a; ex_wdata = wd;
        chk("ex_ready", {31'd0, ex_ready}, 32'd1);
        q.push_back(e);
        cur_st = st; cur_f3 = f3; cur_a = a; cur_wd = wd; cur_split = (e.reqs > 1);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        busy = 1'b1; done_flag = 1'b0; cyc = 0; reqs = 0;
        if (st && !e.exc) begin
            for (int i = 0; i < nbytes(f3); i++) ref_mem[a[15:0] + 16'(i)] = wd[8*i +: 8];
        end
        k = 0;
        while (!done_flag && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!done_flag) begin
            chk("done_timeout", 32'd0, 32'd1);
            busy = 1'b0;
            q.delete();
        end
        @(negedge clk);
        chk("rdata_hold", lsu_rdata, last_rdata);
        chk("cause_hold", {30'd0, lsu_exc_cause}, {30'd0, last_cause});
        $display("xact st=%0b f3=%03b addr=%08h wd=%08h -> rdata=%08h exc=%0b cause=%0d",
                 st, f3, a, wd, last_dut_rdata, e.exc, e.cause);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);

        // Reset values while held in reset
        repeat (3) @(negedge clk);
        chk("rst_done", {31'd0, lsu_done}, 32'd0);
        chk("rst_exc", {31'd0, lsu_exc}, 32'd0);
        chk("rst_cause", {30'd0, lsu_exc_cause}, 32'd0);
        chk("rst_rdata", lsu_rdata, 32'd0);
        chk("rst_req", {31'd0, dm_req}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, ex_ready}, 32'd1);

        // Directed vectors
        xact(1'b0, 3'b010, 32'h0000_4000, 32'd0);          // LW
        chk("lw_deadbeef", last_dut_rdata, 32'hDEAD_BEEF);
        xact(1'b1, 3'b000, 32'h0000_4003, 32'h0000_0080);  // SB 0x80
        xact(1'b0, 3'b000, 32'h0000_4003, 32'd0);          // LB
        chk("lb_sext", last_dut_rdata, 32'hFFFF_FF80);
        xact(1'b0, 3'b100, 32'h0000_4003, 32'd0);          // LBU
        chk("lbu_zext", last_dut_rdata, 32'h0000_0080);
        xact(1'b1, 3'b001, 32'h0000_4002, 32'h0000_1234);  // SH
        xact(1'b0, 3'b010, 32'h0000_4000, 32'd0);          // LW
        chk("sh_then_lw", last_dut_rdata, 32'h1234_BEEF);
        xact(1'b0, 3'b010, 32'h0000_4001, 32'd0);          // misaligned LW
        xact(1'b0, 3'b010, 32'h0000_0100, 32'd0);          // memory fault
        xact(1'b0, 3'b010, 32'h0001_0000, 32'd0);          // out of range
        xact(1'b0, 3'b011, 32'h0000_4000, 32'd0);          // illegal size
        xact(1'b1, 3'b100, 32'h0000_4000, 32'h0000_0055);  // unsigned store
        xact(1'b1, 3'b001, 32'h0000_4005, 32'h0000_ABCD);  // misaligned SH
        xact(1'b0, 3'b101, 32'h0000_4005, 32'd0);          // misaligned LHU
        xact(1'b0, 3'b110, 32'h0001_0001, 32'd0);          // illegal beats range

        // Reset while a load is in ACCESS: no completion may follow
        @(negedge clk);
        ex_valid = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h0000_4000;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_inflight_req", {31'd0, dm_req}, 32'd0);
        chk("rst_inflight_done", {31'd0, lsu_done}, 32'd0);
        chk("rst_inflight_rdata", lsu_rdata, 32'd0);
        last_rdata = 32'd0;
        last_cause = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_done", {31'd0, lsu_done}, 32'd0);
        end
        chk("post_rst_ready", {31'd0, ex_ready}, 32'd1);
        $display("xact reset during ACCESS -> abandoned");

        // Randomised mix
        for (int t = 0; t < 40; t++) begin
            int          r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            if (r == 0)      a = 32'h0000_0100 + $urandom_range(0, 255);
            else if (r == 1) a = 32'h0001_0000 + $urandom_range(0, 255);
            else             a = 32'h0000_4000 + $urandom_range(0, 255);
            xact(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default memory_pkg::MEM_ADDR_WIDTH, data-memory address width.
REQ-002 SHALL have parameter WORD_W, default memory_pkg::MEM_WORD_WIDTH, data word width (32).
REQ-003 SHALL have port clk  in  1  clock; single clock domain, rising edge.
REQ-004 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port ex_valid  in  1  execute stage presents a load/store.
REQ-006 SHALL have port ex_ready  out  1  LSU can accept; high only in IDLE.
REQ-007 SHALL have port ex_store  in  1  1=store, 0=load.
REQ-008 SHALL have port ex_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU/SB/SH/SW).
REQ-009 SHALL have port ex_addr  in  32  effective address from ALU.
REQ-010 SHALL have port ex_wdata  in  WORD_W  store data (rs2).
REQ-011 SHALL have port lsu_done  out  1  one-cycle completion pulse.
REQ-012 SHALL have port lsu_rdata  out  WORD_W  extended load result, valid with lsu_done.
REQ-013 SHALL have port lsu_exc  out  1  exception flag, valid with lsu_done.
REQ-014 SHALL have port lsu_exc_cause  out  2  lsu_exc_e code, valid with lsu_exc.
REQ-015 SHALL have ports dm_req, dm_write_en, dm_l_unsigned (out 1), dm_n_bytes (out 2), dm_addr (out ADDR_W), dm_store_data (out WORD_W): data-memory request.
REQ-016 SHALL have ports dm_load_data (in WORD_W, combinational same cycle as dm_req) and dm_addr_err (in 1, registered, one cycle after dm_req).

Function
REQ-017 SHALL accept a request on ex_valid & ex_ready, latching store, funct3, addr, wdata.
REQ-018 SHALL use FSM states IDLE, ACCESS, RESP; plus SPLIT under LSU_MISALIGN_SPLIT_EN.
REQ-019 SHALL transition IDLE->ACCESS on accept; ACCESS->RESP after one cycle; RESP->IDLE unconditionally.
REQ-020 SHALL assert dm_req only in ACCESS/SPLIT; all dm_* outputs 0 elsewhere.
REQ-021 SHALL map funct3[1:0] 00/01/10 to LS_SINGLE/LS_HALFWORD/LS_WORD; dm_l_unsigned=funct3[2].
REQ-022 SHALL capture dm_load_data into a result register in the ACCESS cycle.
REQ-023 SHALL pulse lsu_done in RESP: aligned access latency = 2 cycles after the accept edge.
REQ-024 SHALL sign/zero-extend LB/LH/LBU/LHU results to 32 bits inside the LSU, independent of memory extension.
REQ-025 SHALL treat funct3 011/110/111, or store with funct3[2]=1, as ILLEGAL_SIZE: no dm_req, IDLE->RESP, lsu_exc=1.
REQ-026 SHALL treat ex_addr[31:ADDR_W] != 0 as ACCESS_FAULT with no dm_req.
REQ-027 SHALL report ACCESS_FAULT in RESP when dm_addr_err=1; lsu_rdata=0 on any exception.
REQ-028 SHALL, without split, flag misaligned half (addr[0]) or word (addr[1:0]!=0) as LOAD_MISALIGN/STORE_MISALIGN with no dm_req.
REQ-029 SHALL give precedence ILLEGAL_SIZE > ACCESS_FAULT(range) > MISALIGN.
REQ-030 SHALL hold lsu_rdata/lsu_exc_cause stable outside RESP (last value); no response backpressure.

Reset
REQ-031 SHALL on rst_n=0 force IDLE, ex_ready=1 after release, lsu_done=0, lsu_exc=0, lsu_exc_cause=0, lsu_rdata=0, dm_req=0, immediately and asynchronously.
REQ-032 SHALL abandon an in-flight access on reset; no lsu_done pulse follows for it.

Configuration
REQ-033 SHALL, with LSU_MISALIGN_SPLIT_EN defined, execute misaligned half/word accesses as 2/4 sequential byte accesses (SPLIT, one byte per cycle, ascending address, l_unsigned=1), assembling little-endian, then RESP.
REQ-034 SHALL in split mode OR dm_addr_err of every byte into a sticky fault; latency = N+1 cycles after accept.
REQ-035 SHALL, without LSU_MISALIGN_SPLIT_EN, behave per REQ-028 and contain no SPLIT logic.

Structure
REQ-036 SHALL place lsu_state_t, lsu_exc_e (LOAD_MISALIGN=0, STORE_MISALIGN=1, ACCESS_FAULT=2, ILLEGAL_SIZE=3), funct3 constants in memory_pkg.
REQ-037 SHALL put byte-lane assembly and extension in sub-module lsu_align (combinational).

Verification
REQ-038 LW addr 0x4000 holding 0xDEADBEEF -> lsu_done 2 cycles after accept, lsu_rdata=0xDEADBEEF, lsu_exc=0.
REQ-039 LB addr 0x4003 byte 0x80 -> 0xFFFFFF80; LBU same -> 0x00000080.
REQ-040 SH 0x1234 at 0x4002 then LW 0x4000 -> upper half 0x1234, lower half unchanged.
REQ-041 LW addr 0x4001: no macro -> lsu_exc=1 cause 0, no dm_req; with macro -> 4 byte reqs, correct word, done at cycle 5.
REQ-042 LW addr 0x0000_0100 -> dm_addr_err -> cause 2; addr 0x0001_0000 -> cause 2, no dm_req; funct3=011 -> cause 3.
REQ-043 rst_n low during ACCESS -> dm_req drops immediately, no lsu_done, ex_ready=1 after release.
